// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit beside the EX-stage ALU.
// It takes one M-extension op from EX, holds the pipeline through stall_req while
// it iterates, and presents a 32-bit result for the EX/MEM alu_result path.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         EX holds a valid M-extension instruction
//   funct3        0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   a, b          forwarded rs1 / rs2 operands
//   flush         kill the in-flight op (branch/jump redirect)
//   advance       pipeline moves EX->MEM this cycle
//   stall_req     EX must not advance (combinational)
//   busy          state is not IDLE
//   done          result valid (registered)
//   result        operation result (registered, held until the next completion)
//
// Build option: define MULDIV_SINGLE_CYCLE_MUL_EN to compute the multiply class
// with a single-cycle 33x33 signed multiplier; divide is unchanged.

module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             advance,
    output logic             stall_req,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CNT_W  = $clog2(ITER);
    localparam int unsigned PROD_W = 2 * WIDTH;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_REM    = 3'd6;

    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [2:0]       op;
    logic             neg;      // result (product / quotient) needs negation
    logic             neg_rem;  // remainder takes the dividend's sign
    logic [WIDTH-1:0] acc_hi;   // product high word / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier bits / dividend-then-quotient bits
    logic [WIDTH-1:0] opnd;     // multiplicand / divisor magnitude

    // Operand sign handling at accept time
    logic             a_sgn, b_sgn, sa, sb;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_sgn = (funct3 == F_MULH) | (funct3 == F_MULHSU) | (funct3 == F_DIV) | (funct3 == F_REM);
    assign b_sgn = (funct3 == F_MULH) | (funct3 == F_DIV) | (funct3 == F_REM);
    assign sa    = a_sgn & a[WIDTH-1];
    assign sb    = b_sgn & b[WIDTH-1];
    assign a_mag = sa ? -a : a;
    assign b_mag = sb ? -b : b;

    // Divide corner cases resolved without iterating
    logic             div_zero, div_ovf, fast_path;
    logic [WIDTH-1:0] fast_res;

    assign div_zero  = funct3[2] & (b == '0);
    assign div_ovf   = funct3[2] & ~funct3[0] & (a == INT_MIN) & (b == '1);
    assign fast_path = div_zero | div_ovf;
    assign fast_res  = div_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : INT_MIN);

    // One shift-add multiply step
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  mul_hi_nx, mul_lo_nx;
    logic [PROD_W-1:0] prod_nx, prod_fix;
    logic [WIDTH-1:0]  mul_res;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};
    assign prod_nx   = {mul_hi_nx, mul_lo_nx};
    assign prod_fix  = neg ? -prod_nx : prod_nx;
    assign mul_res   = (op == F_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[PROD_W-1:WIDTH];

    // One restoring-divide step; bit WIDTH of the trial difference is the borrow
    logic [WIDTH:0]   div_sh, div_tr;
    logic             div_ok;
    logic [WIDTH-1:0] div_hi_nx, div_lo_nx, quot_fix, rem_fix, div_res;

    assign div_sh    = {acc_hi, acc_lo[WIDTH-1]};
    assign div_tr    = div_sh - {1'b0, opnd};
    assign div_ok    = ~div_tr[WIDTH];
    assign div_hi_nx = div_ok ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_lo_nx = {acc_lo[WIDTH-2:0], div_ok};
    assign quot_fix  = neg ? -div_lo_nx : div_lo_nx;
    assign rem_fix   = neg_rem ? -div_hi_nx : div_hi_nx;
    assign div_res   = op[1] ? rem_fix : quot_fix;

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    // Single-cycle multiply: sign/zero-extend to WIDTH+1 bits, keep the low 2*WIDTH
    logic [WIDTH:0]    sc_a, sc_b;
    logic [PROD_W-1:0] sc_p;
    logic [WIDTH-1:0]  sc_res;

    assign sc_a   = {sa, a};
    assign sc_b   = {sb, b};
    assign sc_p   = PROD_W'($signed(sc_a) * $signed(sc_b));
    assign sc_res = (funct3 == F_MUL) ? sc_p[WIDTH-1:0] : sc_p[PROD_W-1:WIDTH];
`endif

    // Hold EX while accepting or iterating; released in DONE so EX can advance
    assign stall_req = ~rst & (((state == IDLE) & start & ~flush) |
                               (state == MUL_RUN) | (state == DIV_RUN));
    assign busy      = (state != IDLE);

    // Sequencer: state, iteration datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            op      <= '0;
            neg     <= 1'b0;
            neg_rem <= 1'b0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            done    <= 1'b0;
            result  <= '0;
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op      <= funct3;
                        neg     <= sa ^ sb;
                        neg_rem <= sa;
                        count   <= '0;
                        if (fast_path) begin
                            result <= fast_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
                        else if (!funct3[2]) begin
                            result <= sc_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
`endif
                        else begin
                            acc_hi <= '0;
                            acc_lo <= funct3[2] ? a_mag : b_mag;
                            opnd   <= funct3[2] ? b_mag : a_mag;
                            state  <= funct3[2] ? DIV_RUN : MUL_RUN;
                        end
                    end
                end
                MUL_RUN: begin
                    acc_hi <= mul_hi_nx;
                    acc_lo <= mul_lo_nx;
                    if (count == CNT_LAST) begin
                        count  <= '0;
                        result <= mul_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DIV_RUN: begin
                    acc_hi <= div_hi_nx;
                    acc_lo <= div_lo_nx;
                    if (count == CNT_LAST) begin
                        count  <= '0;
                        result <= div_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (advance) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + randomized bench for muldiv_sequencer with an expected-result queue.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        advance = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        stall_req, busy, done;
    logic [31:0] result;

    int vectors = 0;
    int miscompares = 0;

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .advance   (advance),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference for RV32M semantics using wide arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = 64'd0;
        case (f)
            3'd0: begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
            3'd1: begin p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return p[63:32]; end
            3'd2: begin p = $signed({{32{x[31]}}, x}) * $signed({32'd0, y}); return p[63:32]; end
            3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'($signed(x) / $signed(y));
            end
            3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 32'd0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                return 32'($signed(x) % $signed(y));
            end
            default: return (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (!f[2]) return MUL_LAT;
        if (y == 32'd0) return 1;
        if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Present an op in IDLE and queue its expected result
    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input string tag);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        a      = x;
        b      = y;
        e.tag  = tag;
        e.val  = exp;
        sb.push_back(e);
        #1;
        chk({tag, " stall_at_accept"}, 32'(stall_req), 32'd1);
    endtask

    // Wait for done (bounded), scramble inputs meanwhile, then check the oldest expectation
    task automatic wait_done(input int lat);
        int   cyc = 0;
        int   st  = 1;
        bit   got = 1'b0;
        exp_t e;
        while (!got && cyc < 100) begin
            @(posedge clk);
            #1;
            start  = 1'b0;
            a      = $urandom;
            b      = $urandom;
            funct3 = 3'($urandom);
            cyc++;
            if (done) got = 1'b1;
            else if (stall_req) st++;
        end
        e = sb.pop_front();
        chk({e.tag, " done_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({e.tag, " result"}, result, e.val);
            chk({e.tag, " latency"}, 32'(cyc), 32'(lat));
            chk({e.tag, " stall_cycles"}, 32'(st), 32'(lat));
            chk({e.tag, " stall_in_done"}, 32'(stall_req), 32'd0);
        end
    endtask

    task automatic retire(input string tag);
        @(negedge clk);
        advance = 1'b1;
        @(posedge clk);
        #1;
        advance = 1'b0;
        chk({tag, " done_after_adv"}, 32'(done), 32'd0);
        chk({tag, " busy_after_adv"}, 32'(busy), 32'd0);
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int lat, input string tag);
        issue(f, x, y, exp, tag);
        wait_done(lat);
        retire(tag);
    endtask

    initial begin
        logic [31:0] held;
        logic [2:0]  rf;
        logic [31:0] rx, ry;
        bit          seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst stall_req", 32'(stall_req), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Multiply class
        run(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "MUL");
        run(3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, MUL_LAT, "MULH");
        run(3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, MUL_LAT, "MULHU");

        // Divide class
        run(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "DIV");
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "REM");
        run(3'd5, 32'd100, 32'd7, 32'd14, 33, "DIVU");
        run(3'd7, 32'd100, 32'd7, 32'd2, 33, "REMU");

        // Divide corner cases
        run(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "DIVU_by0");
        run(3'd6, 32'd5, 32'd0, 32'd5, 1, "REM_by0");
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV_ovf");
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "REM_ovf");

        // Flush a divide at iteration 10: no done pulse, back to IDLE
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; a = 32'd12345; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("flush busy_running", 32'(busy), 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush done", 32'(done), 32'd0);
        chk("flush stall_req", 32'(stall_req), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        chk("flush no_done_pulse", 32'(seen), 32'd0);
        run(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT, "MULHSU_after_flush");

        // Hold in DONE while advance=0; a start there is ignored
        issue(3'd5, 32'd1000, 32'd9, 32'd111, "DIVU_hold");
        wait_done(33);
        held = result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b1; funct3 = 3'd5; a = 32'd7; b = 32'd0;
            @(posedge clk);
            #1;
            chk($sformatf("hold done c%0d", i), 32'(done), 32'd1);
            chk($sformatf("hold result c%0d", i), result, held);
        end
        // start coincident with advance is not accepted either
        @(negedge clk);
        advance = 1'b1;
        @(posedge clk);
        #1;
        advance = 1'b0;
        start   = 1'b0;
        chk("hold done_after_adv", 32'(done), 32'd0);
        chk("hold busy_after_adv", 32'(busy), 32'd0);
        chk("hold result_kept", result, held);

        // Randomized ops against the reference model
        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom);
            rx = $urandom;
            ry = $urandom;
            if (i == 2) ry = 32'd0;
            if (i == 5) ry = $urandom_range(1, 15);
            if (i == 6) rf = 3'd6;
            run(rf, rx, ry, ref_op(rf, rx, ry), ref_lat(rf, rx, ry), $sformatf("rand%0d_f%0d", i, rf));
        end

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; funct3 = 3'd3; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst stall_req", 32'(stall_req), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst done", 32'(done), 32'd0);
        chk("arst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(3'd5, 32'd100, 32'd7, 32'd14, 33, "DIVU_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
